// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator for 3-phase gate drive.
//
// One shared period counter (edge- or center-aligned) feeds NCH compare
// channels. Each channel has a double-buffered duty (shadow -> active at
// the period boundary) and a complementary high/low-side output pair with
// programmable dead time.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         1 = run; 0 = halt, counter to 0, all gate outputs low
//   mode       0 = edge-aligned, 1 = center-aligned (sampled while en=0)
//   duty       packed duties, channel i at [i*WIDTH +: WIDTH]
//   duty_vld   capture duty into the shadow registers
//   dead_time  dead-time cycles shared by all channels (0 = none)
//   pwm_h      high-side gate drive per channel
//   pwm_l      low-side gate drive per channel
//   PWM_synch  one-cycle pulse at period start
//   upd_pend   shadow holds a duty not yet applied
module pwm_multi #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned NCH   = 3,
    parameter int unsigned DT_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic                 duty_vld,
    input  logic [DT_W-1:0]      dead_time,
    output logic [NCH-1:0]       pwm_h,
    output logic [NCH-1:0]       pwm_l,
    output logic                 PWM_synch,
    output logic                 upd_pend
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [DT_W-1:0]  DT_ONE = DT_W'(1);

    logic [WIDTH-1:0]            r_cnt;
    dir_e                        r_dir;
    logic                        r_mode_q;
    logic                        r_run;
    logic [NCH-1:0][WIDTH-1:0]   r_shadow;
    logic [NCH-1:0][WIDTH-1:0]   r_active;
    logic                        r_pending;
    logic [NCH-1:0]              r_raw;
    logic [NCH-1:0][DT_W-1:0]    r_dt;

    logic [WIDTH-1:0]            w_cnt_nxt;
    dir_e                        w_dir_nxt;
    logic                        w_boundary;
    logic [NCH-1:0]              w_raw_nxt;
    logic [NCH-1:0]              w_dt_zero;

    // ------------------------------------------------------------------
    // Period counter: next-state logic
    // ------------------------------------------------------------------
    // r_run is en delayed by one clock. The first running edge reloads 0
    // so that every run starts with a full period and a boundary.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (!en || !r_run) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (!r_mode_q) begin
            w_cnt_nxt = r_cnt + ONE;
            w_dir_nxt = DIR_UP;
        end else if (r_dir == DIR_UP) begin
            if (r_cnt == MAX) begin
                w_cnt_nxt = MAX - ONE;
                w_dir_nxt = DIR_DOWN;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt - ONE;
            if (r_cnt == ONE) begin
                w_dir_nxt = DIR_UP;
            end
        end
    end

    assign w_boundary = en & (w_cnt_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
            r_mode_q <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            r_run <= en;
            if (!en) begin
                r_mode_q <= mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Duty double buffer
    // ------------------------------------------------------------------
    // A strobe on the boundary edge keeps its value pending: the boundary
    // transfers the pre-edge shadow, and the strobe re-arms pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_active <= r_shadow;
            end
            if (duty_vld) begin
                r_shadow  <= duty;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare and dead time
    // ------------------------------------------------------------------
    always_comb begin
        w_raw_nxt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_raw_nxt[i] = en & r_run & (r_cnt < r_active[i]);
        end
    end

    // The counter reloads on the same edge raw changes, so the outputs
    // stay low for exactly dead_time cycles after the last raw edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw <= '0;
            r_dt  <= '0;
        end else begin
            r_raw <= w_raw_nxt;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!en) begin
                    r_dt[i] <= '0;
                end else if (w_raw_nxt[i] != r_raw[i]) begin
                    r_dt[i] <= dead_time;
                end else if (r_dt[i] != '0) begin
                    r_dt[i] <= r_dt[i] - DT_ONE;
                end
            end
        end
    end

    always_comb begin
        w_dt_zero = '0;
        pwm_h     = '0;
        pwm_l     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_dt_zero[i] = (r_dt[i] == '0);
            pwm_h[i]     = r_raw[i] & w_dt_zero[i];
            pwm_l[i]     = ~r_raw[i] & r_run & w_dt_zero[i];
        end
    end

    assign PWM_synch = r_run & (r_cnt == '0);
    assign upd_pend  = r_pending;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel successor to the single-channel PWM generator, for driving 3-phase motor gates.
- One shared period counter serves NCH channels, in edge-aligned or center-aligned mode.
- Per-channel duty is double-buffered and updates only at the period boundary.
- Each channel drives complementary high/low-side outputs with programmable dead time, plus a period-start synch pulse for the ADC/commutation logic.

Parameters:
WIDTH, 11, counter and duty width; MAX = 2^WIDTH-1
NCH, 3, number of channels
DT_W, 6, dead-time counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = run; 0 = halt and force all gate outputs low
mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only while en=0
duty  in  NCH*WIDTH  packed duties; channel i at [i*WIDTH +: WIDTH]
duty_vld  in  1  strobe: capture duty into the shadow registers
dead_time  in  DT_W  dead-time cycles, shared by all channels; 0 = none
pwm_h  out  NCH  high-side gate drive per channel
pwm_l  out  NCH  low-side gate drive per channel
PWM_synch  out  1  one-cycle pulse at period start
upd_pend  out  1  shadow holds a value not yet applied

Behaviour:
Reset values:
- cnt=0, dir=up, mode_q=0; shadow, active and pending cleared.
- raw=0, dead-time counters=0.
- pwm_h=0, pwm_l=0, PWM_synch=0, upd_pend=0.
- Reset is asynchronous and may arrive mid-period; it returns the block to the reset state immediately.

Mode and enable:
- mode_q <= mode on every clock while en=0.
- en=0: cnt held at 0, dir=up, raw=0, pwm_h=pwm_l=0, dead-time counters=0.
- Shadow capture continues while en=0.

Counter:
- Edge mode: cnt 0,1,...,MAX, then wraps to 0. Period = 2^WIDTH cycles.
- Center mode: cnt counts up 0..MAX, then down MAX-1..1, then 0. Period = 2*MAX cycles.
- Period boundary = any clock edge at which cnt is loaded with 0, including the first edge after en rises.

Duty buffering:
- duty_vld=1: shadow <= duty and pending <= 1.
- At a boundary with pending=1: active <= shadow, pending <= 0.
- duty_vld coincident with a boundary: the boundary loads the pre-edge shadow; the new value stays pending for the next boundary.
- upd_pend = pending.

Compare:
- raw[i] <= en & (cnt < active[i]), registered, one cycle after cnt.
- Duty 0 gives raw always 0; maximum edge-mode duty is MAX/2^WIDTH.

Dead time, per channel:
- On any change of raw[i]: pwm_h[i] and pwm_l[i] go to 0 and dt_cnt[i] loads dead_time.
- While dt_cnt[i] != 0: decrement, both outputs held low.
- When dt_cnt[i] = 0: pwm_h[i] = raw[i], pwm_l[i] = ~raw[i] & en.
- A raw change during the countdown reloads the counter.
- dead_time=0: outputs follow raw on the same cycle.
- pwm_h[i] & pwm_l[i] must never both be 1.

Synch:
- PWM_synch = en & (cnt == 0), combinational from the registered cnt.
- Fires once per period in both modes.

Test Plan:
All scenarios use WIDTH=4, NCH=2, DT_W=3.

1. Edge mode, duty0=5, dead_time=0, en=1 → period 16. pwm_h[0] high 5 cycles and pwm_l[0] high 11 cycles per period. PWM_synch pulses every 16 cycles. h and l are never both high.

2. Edge mode, duty0=5, dead_time=2 → per period: pwm_h high 3 cycles, pwm_l high 9 cycles, both low for 2 cycles after each raw edge.

3. Center mode, set while en=0, duty0=4 → period 30; raw high 7 cycles per period (cnt 0-3 up, 3-1 down); PWM_synch every 30 cycles.

4. duty_vld mid-period, duty0 3→10 → upd_pend=1 until the next cnt=0. Current period keeps the old width; the next period shows the new width. Repeat with duty_vld on the boundary edge → change lands one period later.

5. duty=1, dead_time=3 → raw pulses 1 cycle; counter reloads; pwm_h never asserts and both outputs are low for 4 cycles. duty=0 → pwm_h=0 and pwm_l=1 continuously.

6. en dropped mid-period → next cycle pwm_h=pwm_l=0, cnt=0, PWM_synch=0. rst_n asserted mid-period → all outputs 0 immediately, independent of clk; after release, upd_pend=0 and active duty=0.
